// File: rtl/phys_reg_allocator.sv
// Physical register free list: circular buffer, multi-port same-cycle alloc and per-cycle release.
// Grants are combinational from current state; frees land at the edge; clk_en low stalls everything.
module phys_reg_allocator #(
    parameter int CELLS           = 128,
    parameter int RESERVED        = 32,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int PHYS_ADDR_WIDTH = $clog2(CELLS)
) (
    input  logic                                          clk,
    input  logic                                          async_rst_n,
    input  logic                                          clk_en,
    input  logic [ALLOC_PORTS-1:0]                        alloc_req,
    output logic [ALLOC_PORTS-1:0]                        alloc_gnt,
    output logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]   alloc_addr,
    input  logic [FREE_PORTS-1:0]                         free_en,
    input  logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]    free_addr,
    output logic                                          ready,
    output logic [PHYS_ADDR_WIDTH:0]                      free_count,
    output logic                                          err_overflow
);

    localparam int AW  = PHYS_ADDR_WIDTH;
    localparam int CW  = PHYS_ADDR_WIDTH + 1;
    localparam int CAP = CELLS - RESERVED;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t state, state_nx;

    logic [AW-1:0] mem [CELLS];
    logic [AW-1:0] head, tail;

    logic                          active;
    logic [CW-1:0]                 gnt_cnt, acc_cnt, space;
    logic                          drop;
    logic [FREE_PORTS-1:0]         wr_en;
    logic [FREE_PORTS-1:0][AW-1:0] wr_idx;

    assign ready  = (state == ST_READY);
    assign active = clk_en && (state == ST_READY);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) state <= ST_INIT;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clk_en && state == ST_INIT && tail == AW'(CAP - 1))
            state_nx = ST_READY;
    end

    // Grants see only the pre-edge list, so frees from this cycle are never bypassed.
    always_comb begin
        alloc_gnt  = '0;
        alloc_addr = '0;
        gnt_cnt    = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            if (active && alloc_req[i] && gnt_cnt < free_count) begin
                alloc_gnt[i]  = 1'b1;
                alloc_addr[i] = mem[head + gnt_cnt[AW-1:0]];
                gnt_cnt       = gnt_cnt + CW'(1);
            end
        end
    end

    // Room for frees is measured after this cycle's grants have left the list.
    always_comb begin
        space   = CW'(CAP) - (free_count - gnt_cnt);
        acc_cnt = '0;
        drop    = 1'b0;
        wr_en   = '0;
        wr_idx  = '0;
        for (int j = 0; j < FREE_PORTS; j++) begin
            if (active && free_en[j]) begin
                if (acc_cnt < space) begin
                    wr_en[j]  = 1'b1;
                    wr_idx[j] = tail + acc_cnt[AW-1:0];
                    acc_cnt   = acc_cnt + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            head         <= '0;
            tail         <= '0;
            free_count   <= '0;
            err_overflow <= 1'b0;
        end else if (clk_en) begin
            if (state == ST_INIT) begin
                tail       <= tail + AW'(1);
                free_count <= free_count + CW'(1);
            end else begin
                head       <= head + gnt_cnt[AW-1:0];
                tail       <= tail + acc_cnt[AW-1:0];
                free_count <= free_count - gnt_cnt + acc_cnt;
                if (drop) err_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset: every slot read later has been written by INIT or a free.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (state == ST_INIT) begin
                mem[tail] <= AW'(RESERVED) + tail;
            end else begin
                for (int j = 0; j < FREE_PORTS; j++)
                    if (wr_en[j]) mem[wr_idx[j]] <= free_addr[j];
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_allocator.sv
// Randomized scoreboard bench for phys_reg_allocator against a queue-based free-list model.
module tb_phys_reg_allocator;

    localparam int AP  = 4;
    localparam int FP  = 4;
    localparam int AW  = 7;
    localparam int RES = 32;
    localparam int CAP = 128 - RES;

    logic                   clk;
    logic                   async_rst_n;
    logic                   clk_en;
    logic [AP-1:0]          alloc_req;
    logic [AP-1:0]          alloc_gnt;
    logic [AP-1:0][AW-1:0]  alloc_addr;
    logic [FP-1:0]          free_en;
    logic [FP-1:0][AW-1:0]  free_addr;
    logic                   ready;
    logic [AW:0]            free_count;
    logic                   err_overflow;

    phys_reg_allocator #(
        .CELLS(128), .RESERVED(RES), .ALLOC_PORTS(AP), .FREE_PORTS(FP), .PHYS_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
        .free_en(free_en), .free_addr(free_addr),
        .ready(ready), .free_count(free_count), .err_overflow(err_overflow)
    );

    typedef struct {
        logic                  rdy;
        int                    fc;
        logic                  err;
        logic [AP-1:0]         gnt;
        logic [AP-1:0][AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: free list as a plain FIFO of register numbers.
    int   fl[$];
    int   init_k = 0;
    logic m_err  = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ready", int'(ready), int'(e.rdy));
            chk("free_count", int'(free_count), e.fc);
            chk("err_overflow", int'(err_overflow), int'(e.err));
            chk("alloc_gnt", int'(alloc_gnt), int'(e.gnt));
            for (int i = 0; i < AP; i++)
                if (e.gnt[i]) chk($sformatf("alloc_addr%0d", i), int'(alloc_addr[i]), int'(e.addr[i]));
        end
    end

    task automatic cycle(input logic [AP-1:0] req, input logic [FP-1:0] fen,
                         input logic [FP-1:0][AW-1:0] fa, input logic en, input logic rst_n);
        exp_t e;
        int   taken;
        async_rst_n = rst_n;
        clk_en      = en;
        alloc_req   = req;
        free_en     = fen;
        free_addr   = fa;
        e.rdy  = rst_n && (init_k == CAP);
        e.fc   = rst_n ? fl.size() : 0;
        e.err  = rst_n && m_err;
        e.gnt  = '0;
        e.addr = '0;
        taken  = 0;
        if (e.rdy && en) begin
            for (int i = 0; i < AP; i++) begin
                if (req[i] && taken < fl.size()) begin
                    e.gnt[i]  = 1'b1;
                    e.addr[i] = AW'(fl[taken]);
                    taken++;
                end
            end
        end
        exp_q.push_back(e);
        if (!rst_n) begin
            fl.delete();
            init_k = 0;
            m_err  = 1'b0;
        end else if (en) begin
            if (init_k < CAP) begin
                fl.push_back(RES + init_k);
                init_k++;
            end else begin
                repeat (taken) void'(fl.pop_front());
                for (int j = 0; j < FP; j++)
                    if (fen[j]) begin
                        if (fl.size() < CAP) fl.push_back(int'(fa[j]));
                        else m_err = 1'b1;
                    end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycle(input logic en, input logic rst_n);
        logic [FP-1:0][AW-1:0] fa;
        for (int j = 0; j < FP; j++) fa[j] = AW'($urandom_range(0, 127));
        cycle(AP'($urandom), FP'($urandom), fa, en, rst_n);
    endtask

    task automatic drain_to(input int n);
        int c;
        logic [AP-1:0] r;
        while (fl.size() > n) begin
            c = fl.size() - n;
            if (c > AP) c = AP;
            r = AP'((1 << c) - 1);
            cycle(r, '0, '0, 1'b1, 1'b1);
        end
    endtask

    task automatic fill_to(input int n);
        int c;
        logic [FP-1:0] f;
        logic [FP-1:0][AW-1:0] fa;
        while (fl.size() < n) begin
            c = n - fl.size();
            if (c > FP) c = FP;
            f = FP'((1 << c) - 1);
            for (int j = 0; j < FP; j++) fa[j] = AW'($urandom_range(0, 127));
            cycle('0, f, fa, 1'b1, 1'b1);
        end
    endtask

    task automatic run_init();
        int guard;
        guard = 0;
        while (init_k < CAP && guard < 400) begin
            rnd_cycle(1'b1, 1'b1);
            guard++;
        end
    endtask

    initial begin
        logic [FP-1:0][AW-1:0] fa;
        async_rst_n = 1'b1;
        clk_en      = 1'b0;
        alloc_req   = '0;
        free_en     = '0;
        free_addr   = '0;
        #2 async_rst_n = 1'b0;
        @(posedge clk);
        #1;
        cycle('0, '0, '0, 1'b1, 1'b0);
        cycle('0, '0, '0, 1'b1, 1'b0);

        // INIT with a stall window, random requests and frees that must be ignored
        repeat (20) rnd_cycle(1'b1, 1'b1);
        repeat (10) rnd_cycle(1'b0, 1'b1);
        run_init();

        cycle(4'b1111, '0, '0, 1'b1, 1'b1);
        drain_to(2);
        cycle(4'b1011, '0, '0, 1'b1, 1'b1);

        fa = '0;
        fa[0] = 7'd7;
        cycle(4'b0001, 4'b0001, fa, 1'b1, 1'b1);
        cycle(4'b0001, '0, '0, 1'b1, 1'b1);

        fill_to(95);
        cycle('0, 4'b0011, fa, 1'b1, 1'b1);
        cycle('0, '0, '0, 1'b1, 1'b1);

        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 100) drain_to($urandom_range(0, 6));
            rnd_cycle(($urandom_range(0, 7) != 0), 1'b1);
        end

        rnd_cycle(1'b1, 1'b0);
        run_init();
        repeat (150) rnd_cycle(($urandom_range(0, 7) != 0), 1'b1);

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
